// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instruction_fetch                                            |
// | Description : Pipeline fetch stage. It drives the PC to a combinational ROM |
// |               and registers the returned word into IF/ID. It also handles   |
// |               stall, redirect and halt.                                     |
// |               Optional counter: define FETCH_PERF_CNT_EN to add the 32-bit  |
// |               fetch_count output.                                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instruction_fetch #(
  parameter int                PC_W     = 16,
  parameter int                INSTR_W  = 9,
  parameter int                OPC_W    = 5,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(1),
  parameter logic [OPC_W-1:0]  HALT_OP  = 5'b11010
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count
`endif
);

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PC_W-1:0]      r_pc;
  logic [PC_W-1:0]      w_pc_nxt;
  logic                 r_if_valid;
  logic                 w_if_valid_nxt;
  logic [INSTR_W-1:0]   r_if_instr;
  logic [INSTR_W-1:0]   w_if_instr_nxt;
  logic [PC_W-1:0]      r_if_pc;
  logic [PC_W-1:0]      w_if_pc_nxt;
  logic                 w_is_halt;

  assign w_is_halt = (instruction[INSTR_W-1 -: OPC_W] == HALT_OP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_pc       <= RESET_PC;
      r_if_valid <= 1'b0;
      r_if_instr <= '0;
      r_if_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_if_valid <= w_if_valid_nxt;
      r_if_instr <= w_if_instr_nxt;
      r_if_pc    <= w_if_pc_nxt;
    end
  end

  // A redirect outranks stall and halt: the word on the ROM bus is wrong-path.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_if_valid_nxt = r_if_valid;
    w_if_instr_nxt = r_if_instr;
    w_if_pc_nxt    = r_if_pc;
    if (branch_taken) begin
      w_state_nxt    = S_RUN;
      w_pc_nxt       = branch_target;
      w_if_valid_nxt = 1'b0;
    end else if (!stall) begin
      case (r_state)
        S_RUN: begin
          w_if_instr_nxt = instruction;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          if (w_is_halt) begin
            w_state_nxt = S_HALTED;
          end else begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
        end
        S_HALTED: begin
          w_if_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = S_RUN;
        end
      endcase
    end
  end

  assign pc       = r_pc;
  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign halted   = (r_state == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_count;
  logic        w_fetch_accept;

  assign w_fetch_accept = (r_state == S_RUN) && !branch_taken && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_fetch_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instruction_fetch                                         |
// | Description : Self-checking bench for instruction_fetch. It runs directed   |
// |               scenarios and then random cycles against a reference model.   |
// |               The optional counter is checked under FETCH_PERF_CNT_EN.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instruction_fetch;

  localparam logic [4:0] c_HALT = 5'b11010;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic [8:0]  instruction;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        if_valid;
  logic [8:0]  if_instr;
  logic [15:0] if_pc;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  logic [8:0]  rom [0:65535];

  // Reference state: the architectural view of the fetch stage.
  logic [15:0] m_pc;
  logic        m_valid;
  logic [8:0]  m_instr;
  logic [15:0] m_ifpc;
  logic        m_halted;
  logic [31:0] m_count;

  int n_tests;
  int n_fail;

  instruction_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc            (pc),
    .instruction   (instruction),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  assign instruction = rom[pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("pc", 64'(pc), 64'(m_pc));
    check("if_valid", 64'(if_valid), 64'(m_valid));
    check("if_instr", 64'(if_instr), 64'(m_instr));
    check("if_pc", 64'(if_pc), 64'(m_ifpc));
    check("halted", 64'(halted), 64'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 64'(fetch_count), 64'(m_count));
`endif
  endtask

  // One clock: apply inputs, advance the model, compare on the falling edge.
  task automatic step(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic [8:0] word;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    word = rom[m_pc];
    if (r) begin
      m_pc = 16'd1; m_valid = 1'b0; m_instr = '0; m_ifpc = '0;
      m_halted = 1'b0; m_count = '0;
    end else if (b) begin
      m_pc = t; m_valid = 1'b0; m_halted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else begin
      m_instr = word; m_ifpc = m_pc; m_valid = 1'b1; m_count = m_count + 1;
      if (word[8:4] == c_HALT) m_halted = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [8:0] w;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    m_pc = '0; m_valid = 1'b0; m_instr = '0; m_ifpc = '0; m_halted = 1'b0; m_count = '0;
    for (int i = 0; i < 65536; i++) begin
      w = 9'($urandom);
      if (w[8:4] == c_HALT) w[4] = ~w[4];
      rom[i] = w;
    end
    rom[1] = 9'b000010001;
    rom[2] = 9'b000100010;
    rom[3] = 9'b000110011;
    rom[14] = {c_HALT, 4'b0000};

    @(negedge clk);
    step(1, 0, 0, 0);
    check("reset_pc", 64'(pc), 64'd1);

    // Cold start, then advance to pc=5 and stall there.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("start_if_pc", 64'(if_pc), 64'd4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    check("stall_pc", 64'(pc), 64'd5);
    step(0, 0, 0, 0);
    check("resume_if_pc", 64'(if_pc), 64'd5);

    // Redirect with stall in the same cycle at pc=7.
    step(0, 0, 0, 0);
    step(0, 1, 1, 16'd10);
    check("redir_pc", 64'(pc), 64'd10);
    step(0, 0, 0, 0);
    check("redir_if_pc", 64'(if_pc), 64'd10);

    // Run into the halt word at 14.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    check("halt_instr", 64'(if_instr), 64'h1A0);
    check("halt_flag", 64'(halted), 64'd1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("halt_bubble", 64'(if_valid), 64'd0);
    step(0, 0, 0, 0);

    // Leave HALTED through an older branch, then wrap the PC.
    step(0, 0, 1, 16'd2);
    check("unhalt", 64'(halted), 64'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0);
    check("pc_wrap", 64'(pc), 64'd0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    check("mid_reset_pc", 64'(pc), 64'd1);

    // Random phase with halt words sprinkled through the ROM.
    for (int i = 0; i < 65536; i += 13) rom[i] = {c_HALT, 4'($urandom)};
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] t;
      t = ($urandom_range(0, 7) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15))
                                      : 16'($urandom_range(0, 300));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, t);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
